tick_timer_wb: RTL and testbench
================================

# tick_timer_wb

Wishbone-mapped countdown timer clocked by the CPU bus clock, driven by the RTC's 100 Hz tick (`int_o`, a pulse one 10 kHz period wide). It sits directly downstream of the RTC. It resynchronises the tick, counts it down from a software-loaded value, and raises a level interrupt on expiry in one-shot or periodic mode. Software uses it for sleeps and scheduler timeslices without polling `uptime`.

## Interface
- `WIDTH`, 24: counter and reload width in bits (1..32).
- `wb_clk_i`  in  1: bus clock; the only clock in the block.
- `wb_rst_i`  in  1: reset, synchronous, active-high.
- `wb_adr_i`  in  32: byte address; only `[3:2]` decoded.
- `wb_dat_i`  in  32: write data.
- `wb_dat_o`  out  32: registered read data.
- `wb_we_i`  in  1: write enable.
- `wb_sel_i`  in  4: byte lane selects.
- `wb_stb_i`  in  1: strobe.
- `wb_cyc_i`  in  1: cycle.
- `wb_ack_o`  out  1: single-cycle acknowledge.
- `tick_i`  in  1: RTC tick, asynchronous to `wb_clk_i`, high at least 2 bus clocks per pulse.
- `irq_o`  out  1: level interrupt, `EXPIRED & IE`.

## Operation
- Register map (`wb_adr_i[3:2]`):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE.
  - 1 RELOAD `[WIDTH-1:0]`.
  - 2 COUNT `[WIDTH-1:0]`: read gives the live count; write loads the count.
  - 3 STATUS: bit0 EXPIRED, bit1 OVERRUN; write-1-to-clear.
- Unimplemented read bits return 0.
- RELOAD/COUNT writes honour all four `wb_sel_i` lanes. CTRL/STATUS writes use lane 0 only.
- Tick path: 2-flop synchroniser `s1`,`s2`, then register `s3`. `tick_rise = s2 & ~s3`.
- Enabling: a CTRL write taking EN 0→1 also loads COUNT ← RELOAD.
- On `tick_rise` with EN=1:
  - COUNT > 1: decrement.
  - COUNT == 1: COUNT ← 0 and EXPIRED ← 1. If EXPIRED was already 1, also OVERRUN ← 1. Then PERIODIC=1 loads COUNT ← RELOAD in place of 0; PERIODIC=0 clears EN.
  - COUNT == 0: no change; no expiry is generated.
- RELOAD = 0 with PERIODIC: the timer stays idle at 0 and never expires.
- EN=0: ticks are ignored and COUNT holds.

## Timing
- Reset values: `wb_dat_o`=0, `wb_ack_o`=0, `irq_o`=0; CTRL, RELOAD, COUNT, STATUS, `s1..s3` all 0.
- Reset mid-operation clears all of the above on the next edge. A pending ack is dropped.
- Wishbone handshake:
  - `wb_ack_o` ← `wb_cyc_i & wb_stb_i & ~wb_ack_o`, so ack rises one clock after the request.
  - Ack is high for exactly one clock. Held requests are acked every other clock.
  - Writes commit on the same edge that sets ack.
  - `wb_dat_o` is loaded on that edge and holds between reads.
- Tick latency: if `tick_i` rises before edge n, `s1`=1 after n, `s2` after n+1, and `tick_rise` is high during the cycle after n+1. COUNT/EXPIRED update at edge n+2.
- `irq_o` is combinational from the EXPIRED and IE flops. It rises in the same cycle EXPIRED becomes 1.
- Simultaneous events:
  - COUNT write with `tick_rise`: the write wins and the tick is lost.
  - CTRL EN 0→1 with `tick_rise`: the reload wins.
  - STATUS W1C of EXPIRED with a new expiry: set wins. EXPIRED stays 1 and OVERRUN is not set by that expiry.
  - CTRL write clearing EN with `tick_rise`: no decrement.
- Counter arithmetic is `WIDTH` bits, unsigned, and never wraps below 0.

## Test plan
- Reset: assert `wb_rst_i` 2 clocks → all registers read 0, `irq_o`=0, `wb_ack_o`=0. A read of each address acks exactly one clock after `stb`.
- One-shot: RELOAD=3, CTRL=0b101, 3 tick pulses → COUNT reads 2, 1, 0. EXPIRED=1 and `irq_o`=1 two clocks after the 3rd `tick_i` rise, and CTRL.EN reads 0. A 4th tick leaves all state unchanged.
- Periodic/overrun: RELOAD=2, CTRL=0b111, 4 ticks, no clear → COUNT reads 2 after the 2nd and 4th ticks. After the 4th, STATUS=0b11. Writing STATUS=0b11 → STATUS=0 and `irq_o`=0.
- Races:
  - COUNT write of 5 in the same cycle as `tick_rise` → COUNT=5.
  - W1C EXPIRED in the expiry cycle → EXPIRED=1, OVERRUN=0.
- Byte lanes: COUNT=0x123456, then write 0xFFFFFFAA with `wb_sel_i`=0b0001 → COUNT=0x1234AA. IE=0 with EXPIRED=1 → `irq_o`=0.
- Mid-run reset: RELOAD=10, EN, 3 ticks, then reset → COUNT=0 and EN=0. Further ticks leave COUNT at 0.

Source files
------------

// File: rtl/tick_timer_wb.sv
// tick_timer_wb: wishbone countdown timer driven by the RTC 100 Hz tick.
// One-shot or periodic expiry raising a level interrupt.
module tick_timer_wb #(
  parameter int WIDTH = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        tick_i,
  output logic        irq_o
);

  typedef logic [WIDTH-1:0] cnt_t;

  logic s1, s2, s3, tick_rise;
  logic en, periodic, ie, expired, overrun;
  cnt_t reload, count;

  logic en_n, periodic_n, ie_n;
  logic expired_n, overrun_n;
  cnt_t reload_n, count_n;

  logic req, wr;
  logic wr_ctrl, wr_rel, wr_cnt, wr_stat;
  logic clr_exp, tick_act, expire;
  logic [31:0] rdata, rel_wr, cnt_wr;
  logic unused_ok;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] cur,
    input logic [31:0] d,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = sel[i] ? d[i*8 +: 8] : cur[i*8 +: 8];
    return r;
  endfunction

  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr  = req & wb_we_i;

  assign wr_ctrl = wr & (wb_adr_i[3:2] == 2'd0) & wb_sel_i[0];
  assign wr_rel  = wr & (wb_adr_i[3:2] == 2'd1);
  assign wr_cnt  = wr & (wb_adr_i[3:2] == 2'd2);
  assign wr_stat = wr & (wb_adr_i[3:2] == 2'd3) & wb_sel_i[0];
  assign clr_exp = wr_stat & wb_dat_i[0];

  assign rel_wr = lane_merge(32'(reload), wb_dat_i, wb_sel_i);
  assign cnt_wr = lane_merge(32'(count), wb_dat_i, wb_sel_i);

  assign tick_rise = s2 & ~s3;

  // A COUNT write or a CTRL write dropping EN swallows the tick.
  assign tick_act = tick_rise & en & ~wr_cnt
                  & ~(wr_ctrl & ~wb_dat_i[0]);
  assign expire   = tick_act & (count == cnt_t'(1));

  assign irq_o = expired & ie;

  assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0],
                       rel_wr, cnt_wr};

  always_comb begin
    en_n       = en;
    periodic_n = periodic;
    ie_n       = ie;
    reload_n   = reload;
    count_n    = count;
    expired_n  = expired & ~clr_exp;
    overrun_n  = overrun & ~(wr_stat & wb_dat_i[1]);

    if (tick_act && count > cnt_t'(1))
      count_n = count - cnt_t'(1);

    if (expire) begin
      expired_n = 1'b1;
      if (expired && !clr_exp)
        overrun_n = 1'b1;
      if (periodic) begin
        count_n = reload;
      end else begin
        count_n = '0;
        en_n    = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_n       = wb_dat_i[0];
      periodic_n = wb_dat_i[1];
      ie_n       = wb_dat_i[2];
      if (wb_dat_i[0] && !en)
        count_n = reload;
    end

    if (wr_rel)
      reload_n = rel_wr[WIDTH-1:0];
    if (wr_cnt)
      count_n = cnt_wr[WIDTH-1:0];
  end

  always_comb begin
    rdata = '0;
    unique case (wb_adr_i[3:2])
      2'd0: rdata = {29'd0, ie, periodic, en};
      2'd1: rdata = 32'(reload);
      2'd2: rdata = 32'(count);
      2'd3: rdata = {30'd0, overrun, expired};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      reload   <= '0;
      count    <= '0;
      expired  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      s1       <= tick_i;
      s2       <= s1;
      s3       <= s2;
      wb_ack_o <= req;
      if (req && !wb_we_i)
        wb_dat_o <= rdata;
      en       <= en_n;
      periodic <= periodic_n;
      ie       <= ie_n;
      reload   <= reload_n;
      count    <= count_n;
      expired  <= expired_n;
      overrun  <= overrun_n;
    end
  end

endmodule

// File: tb/tb_tick_timer_wb.sv
// tb_tick_timer_wb: directed bench for tick_timer_wb.
// Read expectations queue at request time, compared on ack.
module tb_tick_timer_wb;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_REL  = 2'd1;
  localparam logic [1:0] A_CNT  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        tick_i;
  logic        irq_o;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int lat;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  tick_timer_wb #(.WIDTH(24)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .tick_i   (tick_i),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] a,
                     input logic [31:0] d, input logic [3:0] sel,
                     output int l);
    logic [31:0] e;
    string t;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {28'h0, a, 2'b00};
    wb_dat_i = d;
    wb_sel_i = sel;
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (wb_ack_o !== 1'b1 && l < 4);
    check("ack", {31'd0, wb_ack_o}, 32'd1);
    if (!we && sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      check(t, wb_dat_o, e);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] sel);
    int l;
    bus(1'b1, a, d, sel, l);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string tag, output int l);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    bus(1'b0, a, 32'h0, 4'hF, l);
  endtask

  task automatic rdc(input logic [1:0] a, input logic [31:0] exp,
                     input string tag);
    int l;
    rd(a, exp, tag, l);
  endtask

  task automatic tick(input bit chk, input logic ib,
                      input logic ia);
    @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (chk) check("irq_edge1", {31'd0, irq_o}, {31'd0, ib});
    @(negedge clk);
    if (chk) check("irq_edge2", {31'd0, irq_o}, {31'd0, ia});
    @(negedge clk);
    tick_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_race(input logic [1:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = {28'h0, a, 2'b00};
    wb_dat_i = d;
    wb_sel_i = 4'hF;
    @(negedge clk);
    check("race_ack", {31'd0, wb_ack_o}, 32'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_we_i  = 1'b0;
    wb_sel_i = '0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    tick_i   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_irq", {31'd0, irq_o}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), 32'd0, "rst_reg", lat);
      check("rst_ack_lat", 32'(lat), 32'd1);
    end

    // one-shot
    wr(A_REL, 32'd3, 4'hF);
    wr(A_CTRL, 32'b101, 4'h1);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd2, "os_cnt2");
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd1, "os_cnt1");
    tick(1'b1, 1'b0, 1'b1);
    rdc(A_CNT, 32'd0, "os_cnt0");
    rdc(A_STAT, 32'd1, "os_stat");
    rdc(A_CTRL, 32'b100, "os_ctrl");
    check("os_irq", {31'd0, irq_o}, 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd0, "os4_cnt");
    rdc(A_STAT, 32'd1, "os4_stat");
    rdc(A_CTRL, 32'b100, "os4_ctrl");
    rdc(A_REL, 32'd3, "os4_rel");

    // periodic with overrun
    wr(A_STAT, 32'b11, 4'h1);
    wr(A_REL, 32'd2, 4'hF);
    wr(A_CTRL, 32'b111, 4'h1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd2, "per_cnt_t2");
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd2, "per_cnt_t4");
    rdc(A_STAT, 32'b11, "per_stat");
    check("per_irq", {31'd0, irq_o}, 32'd1);
    wr(A_STAT, 32'b11, 4'h1);
    rdc(A_STAT, 32'd0, "per_clr");
    check("per_irq_clr", {31'd0, irq_o}, 32'd0);

    // COUNT write racing a tick
    wr(A_CTRL, 32'd0, 4'h1);
    wr(A_REL, 32'd9, 4'hF);
    wr(A_CTRL, 32'b011, 4'h1);
    rdc(A_CNT, 32'd9, "race_pre");
    tick_race(A_CNT, 32'd5);
    rdc(A_CNT, 32'd5, "race_cnt");

    // W1C racing an expiry
    wr(A_CTRL, 32'd0, 4'h1);
    wr(A_STAT, 32'b11, 4'h1);
    wr(A_REL, 32'd1, 4'hF);
    wr(A_CTRL, 32'b011, 4'h1);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_STAT, 32'd1, "w1c_pre");
    tick_race(A_STAT, 32'd1);
    rdc(A_STAT, 32'd1, "w1c_race");
    rdc(A_CNT, 32'd1, "w1c_cnt");

    // byte lanes, IE gating, EN=0 hold
    wr(A_CTRL, 32'd0, 4'h1);
    wr(A_CNT, 32'h0012_3456, 4'hF);
    wr(A_CNT, 32'hFFFF_FFAA, 4'h1);
    rdc(A_CNT, 32'h0012_34AA, "lane_cnt");
    check("ie0_irq", {31'd0, irq_o}, 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'h0012_34AA, "en0_hold");
    wr(A_CTRL, 32'b100, 4'h1);
    check("ie1_irq", {31'd0, irq_o}, 32'd1);
    wr(A_CTRL, 32'd0, 4'h1);
    wr(A_STAT, 32'b11, 4'h1);

    // RELOAD=0 periodic stays idle
    wr(A_REL, 32'd0, 4'hF);
    wr(A_CTRL, 32'b111, 4'h1);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd0, "rel0_cnt");
    rdc(A_STAT, 32'd0, "rel0_stat");
    wr(A_CTRL, 32'd0, 4'h1);

    // mid-run reset
    wr(A_REL, 32'd10, 4'hF);
    wr(A_CTRL, 32'b001, 4'h1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd7, "mr_cnt7");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdc(A_CNT, 32'd0, "mr_cnt");
    rdc(A_CTRL, 32'd0, "mr_ctrl");
    rdc(A_REL, 32'd0, "mr_rel");
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rdc(A_CNT, 32'd0, "mr_post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
